// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared opcodes, class enum, ALU codes and decoded-bundle type for the decode stage
package idu_pkg;

    parameter int PKG_XLEN     = 32;
    parameter int PKG_ALU_OP_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } inst_class_e;

    localparam logic [PKG_ALU_OP_W-1:0] ALU_ADD   = PKG_ALU_OP_W'(0);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SUB   = PKG_ALU_OP_W'(1);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SLL   = PKG_ALU_OP_W'(2);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SLT   = PKG_ALU_OP_W'(3);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SLTU  = PKG_ALU_OP_W'(4);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_XOR   = PKG_ALU_OP_W'(5);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SRL   = PKG_ALU_OP_W'(6);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_SRA   = PKG_ALU_OP_W'(7);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_OR    = PKG_ALU_OP_W'(8);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_AND   = PKG_ALU_OP_W'(9);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_PASSB = PKG_ALU_OP_W'(10);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BEQ   = PKG_ALU_OP_W'(11);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BNE   = PKG_ALU_OP_W'(12);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BLT   = PKG_ALU_OP_W'(13);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BGE   = PKG_ALU_OP_W'(14);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BLTU  = PKG_ALU_OP_W'(15);
    localparam logic [PKG_ALU_OP_W-1:0] ALU_BGEU  = PKG_ALU_OP_W'(16);

    typedef struct packed {
        logic [PKG_XLEN-1:0]     pc;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [PKG_XLEN-1:0]     imm;
        logic [PKG_ALU_OP_W-1:0] alu_op;
        inst_class_e             cls;
        logic                    rd_we;
        logic                    mem_rd;
        logic                    mem_wr;
        logic                    ebreak;
        logic                    ecall;
        logic                    illegal;
        logic [11:0]             csr_addr;
    } bundle_t;

endpackage

// File: rtl/idu_stream_if.sv
// rtl/idu_stream_if.sv - IFU-side and EXU-side handshake bundle of the decode stage
// master: drives in_valid/in_inst/in_pc/out_ready (IFU + EXU side)
// slave : drives in_ready and all out_* (the decode stage)
interface idu_stream_if
    import idu_pkg::*;
#(
    parameter int XLEN     = PKG_XLEN,
    parameter int ALU_OP_W = PKG_ALU_OP_W
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [XLEN-1:0]     out_imm;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [3:0]          out_class;
    logic                out_rd_we;
    logic                out_mem_rd;
    logic                out_mem_wr;
    logic                out_ebreak;
    logic                out_ecall;
    logic                out_illegal;
    logic [11:0]         out_csr_addr;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_class, out_rd_we, out_mem_rd, out_mem_wr,
               out_ebreak, out_ecall, out_illegal, out_csr_addr
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_class, out_rd_we, out_mem_rd, out_mem_wr,
               out_ebreak, out_ecall, out_illegal, out_csr_addr
    );
endinterface

// File: rtl/idu_decode_comb.sv
// rtl/idu_decode_comb.sv - combinational instruction word + pc to decoded bundle
// Ports: i_inst (32b instruction), i_pc (XLEN pc), o_bundle (bundle_t)
// Macro IDU_ZICSR_EN: decode SYSTEM funct3!=0 as CSR accesses; otherwise they are illegal.
module idu_decode_comb
    import idu_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output bundle_t         o_bundle
);
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_shamt_ok;
    logic       w_legal;
    logic       w_writes;
    bundle_t    w_b;

    // Sign extension is done by size-casting signed fragments to XLEN.
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = i_inst[31:20];
    assign w_imm_s = {i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // On RV64 inst[25] belongs to the 6-bit shamt; on RV32 it must be zero.
    always_comb begin
        w_shamt_ok = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
            if (XLEN == 64)
                w_shamt_ok = (w_f7[6:1] == 6'b000000) ||
                             (w_f3 == 3'b101 && w_f7[6:1] == 6'b010000);
            else
                w_shamt_ok = (w_f7 == 7'b0000000) ||
                             (w_f3 == 3'b101 && w_f7 == 7'b0100000);
        end
    end

    always_comb begin
        w_b        = '0;
        w_b.pc     = i_pc;
        w_b.cls    = CLS_ILLEGAL;
        w_b.alu_op = ALU_ADD;
        w_legal    = 1'b1;
        w_writes   = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_b.cls = CLS_LUI;  w_writes = 1'b1;
                w_b.imm = XLEN'(w_imm_u);  w_b.alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                w_b.cls = CLS_AUIPC;  w_writes = 1'b1;  w_b.imm = XLEN'(w_imm_u);
            end
            OPC_JAL: begin
                w_b.cls = CLS_JAL;  w_writes = 1'b1;  w_b.imm = XLEN'(w_imm_j);
            end
            OPC_JALR: begin
                w_b.cls = CLS_JALR;  w_writes = 1'b1;
                w_b.rs1 = i_inst[19:15];  w_b.imm = XLEN'(w_imm_i);
            end
            OPC_BRANCH: begin
                w_b.cls = CLS_BRANCH;  w_b.rs1 = i_inst[19:15];  w_b.rs2 = i_inst[24:20];
                w_b.imm = XLEN'(w_imm_b);
                case (w_f3)
                    3'b001:  w_b.alu_op = ALU_BNE;
                    3'b100:  w_b.alu_op = ALU_BLT;
                    3'b101:  w_b.alu_op = ALU_BGE;
                    3'b110:  w_b.alu_op = ALU_BLTU;
                    3'b111:  w_b.alu_op = ALU_BGEU;
                    default: w_b.alu_op = ALU_BEQ;
                endcase
            end
            OPC_LOAD: begin
                w_b.cls = CLS_LOAD;  w_writes = 1'b1;  w_b.mem_rd = 1'b1;
                w_b.rs1 = i_inst[19:15];  w_b.imm = XLEN'(w_imm_i);
            end
            OPC_STORE: begin
                w_b.cls = CLS_STORE;  w_b.mem_wr = 1'b1;
                w_b.rs1 = i_inst[19:15];  w_b.rs2 = i_inst[24:20];  w_b.imm = XLEN'(w_imm_s);
            end
            OPC_OPIMM: begin
                w_b.cls = CLS_OPIMM;  w_writes = 1'b1;  w_legal = w_shamt_ok;
                w_b.rs1 = i_inst[19:15];  w_b.imm = XLEN'(w_imm_i);
                case (w_f3)
                    3'b001:  w_b.alu_op = ALU_SLL;
                    3'b010:  w_b.alu_op = ALU_SLT;
                    3'b011:  w_b.alu_op = ALU_SLTU;
                    3'b100:  w_b.alu_op = ALU_XOR;
                    3'b101:  w_b.alu_op = i_inst[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_b.alu_op = ALU_OR;
                    3'b111:  w_b.alu_op = ALU_AND;
                    default: w_b.alu_op = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                w_b.cls = CLS_OP;  w_writes = 1'b1;
                w_b.rs1 = i_inst[19:15];  w_b.rs2 = i_inst[24:20];
                case (w_f3)
                    3'b001:  w_b.alu_op = ALU_SLL;
                    3'b010:  w_b.alu_op = ALU_SLT;
                    3'b011:  w_b.alu_op = ALU_SLTU;
                    3'b100:  w_b.alu_op = ALU_XOR;
                    3'b101:  w_b.alu_op = i_inst[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_b.alu_op = ALU_OR;
                    3'b111:  w_b.alu_op = ALU_AND;
                    default: w_b.alu_op = i_inst[30] ? ALU_SUB : ALU_ADD;
                endcase
            end
            OPC_SYSTEM: begin
                if (i_inst == INST_EBREAK) begin
                    w_b.cls = CLS_SYSTEM;  w_b.ebreak = 1'b1;
                end else if (i_inst == INST_ECALL) begin
                    w_b.cls = CLS_SYSTEM;  w_b.ecall = 1'b1;
`ifdef IDU_ZICSR_EN
                end else if (w_f3 != 3'b000) begin
                    // Immediate CSR forms carry zimm in the rs1 field.
                    w_b.cls      = CLS_SYSTEM;  w_writes = 1'b1;  w_b.alu_op = ALU_PASSB;
                    w_b.csr_addr = i_inst[31:20];
                    w_b.rs1      = w_f3[2] ? 5'd0 : i_inst[19:15];
                    w_b.imm      = w_f3[2] ? XLEN'(i_inst[19:15]) : '0;
`endif
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase

        if (w_writes) begin
            w_b.rd    = i_inst[11:7];
            w_b.rd_we = (i_inst[11:7] != 5'd0);
        end

        // Illegal bundles keep only their pc so the EXU sees a clean trap record.
        if (!w_legal) begin
            w_b         = '0;
            w_b.pc      = i_pc;
            w_b.cls     = CLS_ILLEGAL;
            w_b.illegal = 1'b1;
        end
    end

    assign o_bundle = w_b;
endmodule

// File: rtl/idu_stream.sv
// rtl/idu_stream.sv - decode stage: decodes IFU instructions into a DEPTH-entry bundle queue for the EXU
// Ports: clk, rst (async active-low), flush (drops queue and this cycle's input),
//        bus (idu_stream_if.slave: in_* handshake from IFU, out_* head bundle to EXU)
// Macro IDU_ZICSR_EN: enables CSR decode in idu_decode_comb.
module idu_stream
    import idu_pkg::*;
#(
    parameter int XLEN     = PKG_XLEN,
    parameter int DEPTH    = 2,
    parameter int ALU_OP_W = PKG_ALU_OP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    idu_stream_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    bundle_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    bundle_t w_dec;
    bundle_t w_head;
    logic    w_push;
    logic    w_pop;
    logic    w_not_full;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    idu_decode_comb #(.XLEN(XLEN)) u_dec (
        .i_inst   (bus.in_inst),
        .i_pc     (bus.in_pc),
        .o_bundle (w_dec)
    );

    // No full-bypass: a same-cycle pop does not open a slot.
    assign w_not_full   = (r_count < CNT_W'(DEPTH));
    assign bus.in_ready = rst & w_not_full;
    assign w_push       = bus.in_valid & bus.in_ready & ~flush;
    assign w_pop        = (r_count != '0) & bus.out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the empty-queue mask below hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    assign bus.out_valid    = (r_count != '0);
    assign bus.out_pc       = w_head.pc;
    assign bus.out_rs1      = w_head.rs1;
    assign bus.out_rs2      = w_head.rs2;
    assign bus.out_rd       = w_head.rd;
    assign bus.out_imm      = w_head.imm;
    assign bus.out_alu_op   = w_head.alu_op;
    assign bus.out_class    = w_head.cls;
    assign bus.out_rd_we    = w_head.rd_we;
    assign bus.out_mem_rd   = w_head.mem_rd;
    assign bus.out_mem_wr   = w_head.mem_wr;
    assign bus.out_ebreak   = w_head.ebreak;
    assign bus.out_ecall    = w_head.ecall;
    assign bus.out_illegal  = w_head.illegal;
    assign bus.out_csr_addr = w_head.csr_addr;
endmodule

// File: tb/tb_idu_stream.sv
// tb/tb_idu_stream.sv - self-checking bench for idu_stream with a queue-based reference model
module tb_idu_stream;
    import idu_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int AW    = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [3:0]  cls;
        logic        rd_we, mrd, mwr, ebk, ecl, ill;
        logic [11:0] csr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mq[$];
    logic [31:0] pc_cnt = 32'h8000_0000;

    idu_stream_if #(.XLEN(XLEN), .ALU_OP_W(AW)) bus ();

    idu_stream #(.XLEN(XLEN), .DEPTH(DEPTH), .ALU_OP_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: pick format and operand usage per opcode, then build fields arithmetically.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   v;
        int   f3;
        bit   u1, u2, wr, ill;
        byte  fmt;
        e = '0; e.pc = pc; u1 = 0; u2 = 0; wr = 0; ill = 0; fmt = "R"; v = 0;
        f3 = int'(w[14:12]);
        e.alu = ALU_ADD;
        case (w[6:0])
            7'h37: begin e.cls = CLS_LUI;   fmt = "U"; wr = 1; e.alu = ALU_PASSB; end
            7'h17: begin e.cls = CLS_AUIPC; fmt = "U"; wr = 1; end
            7'h6f: begin e.cls = CLS_JAL;   fmt = "J"; wr = 1; end
            7'h67: begin e.cls = CLS_JALR;  fmt = "I"; wr = 1; u1 = 1; end
            7'h63: begin
                e.cls = CLS_BRANCH; fmt = "B"; u1 = 1; u2 = 1;
                e.alu = (f3 == 1) ? ALU_BNE : (f3 == 4) ? ALU_BLT : (f3 == 5) ? ALU_BGE :
                        (f3 == 6) ? ALU_BLTU : (f3 == 7) ? ALU_BGEU : ALU_BEQ;
            end
            7'h03: begin e.cls = CLS_LOAD;  fmt = "I"; wr = 1; u1 = 1; e.mrd = 1; end
            7'h23: begin e.cls = CLS_STORE; fmt = "S"; u1 = 1; u2 = 1; e.mwr = 1; end
            7'h13, 7'h33: begin
                if (w[6:0] == 7'h13) begin e.cls = CLS_OPIMM; fmt = "I"; end
                else begin e.cls = CLS_OP; u2 = 1; end
                wr = 1; u1 = 1;
                case (f3)
                    0: e.alu = (w[6:0] == 7'h33 && w[30]) ? ALU_SUB : ALU_ADD;
                    1: e.alu = ALU_SLL;
                    2: e.alu = ALU_SLT;
                    3: e.alu = ALU_SLTU;
                    4: e.alu = ALU_XOR;
                    5: e.alu = w[30] ? ALU_SRA : ALU_SRL;
                    6: e.alu = ALU_OR;
                    default: e.alu = ALU_AND;
                endcase
                if (w[6:0] == 7'h13 && (f3 == 1 || f3 == 5))
                    ill = !((w[31:25] == 7'h00) || (f3 == 5 && w[31:25] == 7'h20));
            end
            7'h73: begin
                if (w == 32'h0010_0073) begin e.cls = CLS_SYSTEM; e.ebk = 1; end
                else if (w == 32'h0000_0073) begin e.cls = CLS_SYSTEM; e.ecl = 1; end
`ifdef IDU_ZICSR_EN
                else if (f3 != 0) begin
                    e.cls = CLS_SYSTEM; wr = 1; e.alu = ALU_PASSB; e.csr = w[31:20];
                    u1 = (f3 < 4);
                    if (f3 >= 4) v = int'(w[19:15]);
                end
`endif
                else ill = 1;
            end
            default: ill = 1;
        endcase
        case (fmt)
            "I": v = int'($signed(w)) >>> 20;
            "S": v = (int'($signed(w)) >>> 25) * 32 + int'(w[11:7]);
            "B": v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            "U": v = int'(w & 32'hFFFF_F000);
            "J": v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: ;
        endcase
        e.imm   = v;
        e.rs1   = u1 ? w[19:15] : 5'd0;
        e.rs2   = u2 ? w[24:20] : 5'd0;
        e.rd    = wr ? w[11:7] : 5'd0;
        e.rd_we = wr && (w[11:7] != 0);
        if (ill) begin
            e = '0; e.pc = pc; e.cls = CLS_ILLEGAL; e.ill = 1;
        end
        return e;
    endfunction

    task automatic check_head();
        exp_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", bus.out_valid, mq.size() > 0);
        chk("out_pc",    bus.out_pc,    e.pc);
        chk("out_rs1",   bus.out_rs1,   e.rs1);
        chk("out_rs2",   bus.out_rs2,   e.rs2);
        chk("out_rd",    bus.out_rd,    e.rd);
        chk("out_imm",   bus.out_imm,   e.imm);
        chk("out_alu",   bus.out_alu_op, e.alu);
        chk("out_class", bus.out_class, e.cls);
        chk("out_rd_we", bus.out_rd_we, e.rd_we);
        chk("out_mem_rd", bus.out_mem_rd, e.mrd);
        chk("out_mem_wr", bus.out_mem_wr, e.mwr);
        chk("out_ebreak", bus.out_ebreak, e.ebk);
        chk("out_ecall",  bus.out_ecall,  e.ecl);
        chk("out_illegal", bus.out_illegal, e.ill);
        chk("out_csr",   bus.out_csr_addr, e.csr);
    endtask

    // One clock: drive, check in_ready, take the edge, update model, check head.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
        bit do_push, do_pop;
        logic [31:0] pc;
        pc = pc_cnt;
        bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", bus.in_ready, mq.size() < DEPTH);
        do_push = v && (mq.size() < DEPTH) && !fl;
        do_pop  = (mq.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ref_decode(inst, pc));
        end
        if (v) pc_cnt = pc_cnt + 4;
        check_head();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [2:0]  f3;
        r  = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 10))
            0: return {r[31:7], OPC_LUI};
            1: return {r[31:7], OPC_AUIPC};
            2: return {r[31:7], OPC_JAL};
            3: return {r[31:7], OPC_JALR};
            4: begin
                if (f3[2:1] == 2'b01) f3[1] = 1'b0;
                return {r[31:15], f3, r[11:7], OPC_BRANCH};
            end
            5: return {r[31:7], OPC_LOAD};
            6: return {r[31:7], OPC_STORE};
            7: begin
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
                return {r[31:7], OPC_OPIMM};
            end
            8: return {r[31:7], OPC_OP};
            9: case ($urandom_range(0, 3))
                   0: return INST_EBREAK;
                   1: return INST_ECALL;
                   2: return {r[31:15], 3'b000, r[11:7], OPC_SYSTEM};
                   default: return {r[31:7], OPC_SYSTEM};
               endcase
            default: return r;
        endcase
    endfunction

    initial begin
        rst = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        check_head();
        @(negedge clk);
        rst = 1'b1;

        // addi x1,x0,5
        cycle(1, 32'h0050_0093, 1, 0);
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_class", bus.out_class, CLS_OPIMM);
        chk("addi_rd",    bus.out_rd, 5'd1);
        chk("addi_rs1",   bus.out_rs1, 5'd0);
        chk("addi_imm",   bus.out_imm, 32'd5);
        chk("addi_rd_we", bus.out_rd_we, 1'b1);
        chk("addi_pc",    bus.out_pc, 32'h8000_0000);

        // sw x1,4(x2) while addi pops
        cycle(1, 32'h0011_2223, 1, 0);
        chk("sw_rd",    bus.out_rd, 5'd0);
        chk("sw_rd_we", bus.out_rd_we, 1'b0);
        chk("sw_mem_wr", bus.out_mem_wr, 1'b1);
        chk("sw_rs1",   bus.out_rs1, 5'd2);
        chk("sw_rs2",   bus.out_rs2, 5'd1);
        chk("sw_imm",   bus.out_imm, 32'd4);
        cycle(0, 0, 1, 0);

        // Fill to DEPTH with the EXU stalled; then a pop while full must not raise in_ready.
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'h0000_0013 | (i << 7), 0, 0);
        chk("full_in_ready", bus.in_ready, 1'b0);
        cycle(1, 32'h0010_0093, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, 0);

        // slli with inst[25]=1 is illegal on RV32
        cycle(1, 32'h0200_9093, 0, 0);
        chk("slli_ill",   bus.out_illegal, 1'b1);
        chk("slli_class", bus.out_class, CLS_ILLEGAL);
        chk("slli_rd_we", bus.out_rd_we, 1'b0);
        cycle(0, 0, 1, 0);

        // Flush with a full queue, then with one entry and in_ready high.
        cycle(1, 32'h0050_0093, 0, 0);
        cycle(1, 32'h0060_0113, 0, 0);
        cycle(1, 32'h0070_0193, 0, 1);
        chk("flush_valid", bus.out_valid, 1'b0);
        cycle(1, 32'h0080_0213, 0, 0);
        cycle(1, 32'h0090_0293, 0, 1);
        cycle(0, 0, 1, 0);
        chk("flush2_valid", bus.out_valid, 1'b0);

        // ebreak and the csrr word
        cycle(1, 32'h0010_0073, 0, 0);
        chk("ebreak_flag", bus.out_ebreak, 1'b1);
        chk("ebreak_class", bus.out_class, CLS_SYSTEM);
        cycle(1, 32'h3000_2573, 1, 0);
`ifdef IDU_ZICSR_EN
        chk("csr_addr", bus.out_csr_addr, 12'h300);
        chk("csr_rd",   bus.out_rd, 5'd10);
`else
        chk("csr_ill",  bus.out_illegal, 1'b1);
        chk("csr_zero", bus.out_csr_addr, 12'h000);
`endif
        cycle(0, 0, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0);

        // Asynchronous reset in the middle of a cycle with a full queue.
        cycle(1, 32'h0050_0093, 0, 0);
        cycle(1, 32'h0060_0113, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b0);
        chk("arst_pc", bus.out_pc, 32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 1, 0);
        cycle(1, 32'h0050_0093, 1, 0);
        cycle(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
